// File: rtl/display_pkg.sv
// Shared types and helpers for multiplexed display blocks (scanners, segment decoders).
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    function automatic int idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/next_digit_finder.sv
// Combinational search for the nearest enabled digit after idx_i in the dir_i direction,
// wrapping modulo digits_p; the current digit itself is never a candidate.
module next_digit_finder
    import display_pkg::*;
#(
    parameter int digits_p = 4,
    parameter int IW       = idx_w(digits_p)
) (
    input  logic [digits_p-1:0] mask_i,
    input  logic [IW-1:0]       idx_i,
    input  logic                dir_i,
    output logic [IW-1:0]       next_o,
    output logic                found_o
);

    int pos;

    // Walk from the farthest offset inward so the nearest enabled digit wins.
    always_comb begin
        next_o  = idx_i;
        found_o = 1'b0;
        pos     = 0;
        for (int k = digits_p - 1; k >= 1; k--) begin
            pos = dir_i ? (int'(idx_i) + digits_p - k) : (int'(idx_i) + k);
            if (pos >= digits_p) pos = pos - digits_p;
            if (mask_i[IW'(pos)]) begin
                next_o  = IW'(pos);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// Multiplexed display scanner: slot counter, blank/drive sequencing, masked digit
// rotation and registered select/index/slot/blank outputs.
module digit_scanner
    import display_pkg::*;
#(
    parameter int digits_p     = 4,
    parameter int div_p        = 100000,
    parameter int blank_p      = 1000,
    parameter bit active_low_p = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [digits_p-1:0]          mask_i,
    input  logic                         dir_i,
    output logic [digits_p-1:0]          sel_o,
    output logic [$clog2(digits_p)-1:0]  idx_o,
    output logic                         slot_o,
    output logic                         blank_o
);

    localparam int IW = idx_w(digits_p);
    localparam int CW = $clog2(div_p);
    localparam logic [CW-1:0]       CNT_LAST  = CW'(div_p - 1);
    localparam logic [CW-1:0]       CNT_BLANK = CW'(blank_p);
    localparam logic [digits_p-1:0] SEL_OFF   = {digits_p{active_low_p}};

    scan_state_e         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [digits_p-1:0] sel_q, sel_d;
    logic                slot_q, slot_d;
    logic                blank_q, blank_d;
    logic [IW-1:0]       nxt_idx;
    logic                nxt_found;
    logic                live;

    next_digit_finder #(.digits_p(digits_p), .IW(IW)) u_find (
        .mask_i  (mask_i),
        .idx_i   (idx_q),
        .dir_i   (dir_i),
        .next_o  (nxt_idx),
        .found_o (nxt_found)
    );

    // Outputs are computed from the next-cycle counter/index so they line up with cnt.
    always_comb begin
        cnt_d   = '0;
        idx_d   = idx_q;
        slot_d  = 1'b0;
        state_d = IDLE;
        if (en_i) begin
            if (state_q == IDLE) begin
                slot_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                slot_d = 1'b1;
                if (nxt_found) idx_d = nxt_idx;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = (cnt_d < CNT_BLANK) ? BLANK : DRIVE;
        end
        live    = (state_d == DRIVE) && mask_i[idx_d];
        sel_d   = SEL_OFF;
        if (live) sel_d[idx_d] = ~active_low_p;
        blank_d = ~live;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= SEL_OFF;
            slot_q  <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            slot_q  <= slot_d;
            blank_q <= blank_d;
        end
    end

    assign sel_o   = sel_q;
    assign idx_o   = idx_q;
    assign slot_o  = slot_q;
    assign blank_o = blank_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner: 4-digit active-low instance and 3-digit active-high instance.
module tb_digit_scanner;

    logic       clk;
    logic       rst_a, en_a, dir_a, slot_a, blank_a;
    logic [3:0] mask_a, sel_a;
    logic [1:0] idx_a;
    logic       rst_b, en_b, dir_b, slot_b, blank_b;
    logic [2:0] mask_b, sel_b;
    logic [1:0] idx_b;

    int n_vec = 0;
    int n_err = 0;

    digit_scanner #(.digits_p(4), .div_p(8), .blank_p(2), .active_low_p(1'b1)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .mask_i(mask_a), .dir_i(dir_a),
        .sel_o(sel_a), .idx_o(idx_a), .slot_o(slot_a), .blank_o(blank_a)
    );

    digit_scanner #(.digits_p(3), .div_p(8), .blank_p(2), .active_low_p(1'b0)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .mask_i(mask_b), .dir_i(dir_b),
        .sel_o(sel_b), .idx_o(idx_b), .slot_o(slot_b), .blank_o(blank_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] onehot_lo(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    task automatic cyc_a(input int c, input int idx, input logic [3:0] drv_sel, input logic drv_blank);
        @(negedge clk);
        chk($sformatf("A idx c%0d", c), 32'(idx_a), 32'(idx));
        chk($sformatf("A sel c%0d i%0d", c, idx), 32'(sel_a), (c < 2) ? 32'hF : 32'(drv_sel));
        chk($sformatf("A blank c%0d", c), 32'(blank_a), (c < 2) ? 32'd1 : 32'(drv_blank));
        chk($sformatf("A slot c%0d", c), 32'(slot_a), (c == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic slot_run_a(input int idx, input logic [3:0] drv_sel, input logic drv_blank);
        for (int c = 0; c < 8; c++) cyc_a(c, idx, drv_sel, drv_blank);
    endtask

    task automatic idle_a(input string tag, input int idx);
        chk({tag, " idx"}, 32'(idx_a), 32'(idx));
        chk({tag, " sel"}, 32'(sel_a), 32'hF);
        chk({tag, " blank"}, 32'(blank_a), 32'd1);
        chk({tag, " slot"}, 32'(slot_a), 32'd0);
    endtask

    task automatic cyc_b(input int c, input int idx);
        logic [2:0] one;
        one = 3'b001;
        @(negedge clk);
        chk($sformatf("B idx c%0d", c), 32'(idx_b), 32'(idx));
        chk($sformatf("B sel c%0d i%0d", c, idx), 32'(sel_b), (c < 2) ? 32'h0 : 32'(one << idx));
        chk($sformatf("B blank c%0d", c), 32'(blank_b), (c < 2) ? 32'd1 : 32'd0);
        chk($sformatf("B slot c%0d", c), 32'(slot_b), (c == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; mask_a = 4'b1111; dir_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b1; mask_b = 3'b111;  dir_b = 1'b0;
        repeat (2) @(negedge clk);
        idle_a("A reset", 0);
        chk("B reset sel", 32'(sel_b), 32'h0);
        chk("B reset blank", 32'(blank_b), 32'd1);
        chk("B reset idx", 32'(idx_b), 32'd0);
        rst_a = 1'b0;

        // Full ascending scan 0,1,2,3,0
        for (int s = 0; s < 5; s++) slot_run_a(s % 4, onehot_lo(s % 4), 1'b0);

        // Sparse mask, descending: 0 -> 3,1,3,1
        mask_a = 4'b1010; dir_a = 1'b1;
        slot_run_a(3, onehot_lo(3), 1'b0);
        slot_run_a(1, onehot_lo(1), 1'b0);
        slot_run_a(3, onehot_lo(3), 1'b0);
        slot_run_a(1, onehot_lo(1), 1'b0);

        // Single digit: idx settles at 2, slots still restart
        mask_a = 4'b0100;
        slot_run_a(2, 4'b1011, 1'b0);
        slot_run_a(2, 4'b1011, 1'b0);

        // Empty mask: idx held, display fully blank
        mask_a = 4'b0000;
        slot_run_a(2, 4'hF, 1'b1);

        // Enable drop mid-drive at cnt=5, then resume on same idx
        mask_a = 4'b1111; dir_a = 1'b0;
        for (int c = 0; c < 6; c++) cyc_a(c, 3, onehot_lo(3), 1'b0);
        en_a = 1'b0;
        @(negedge clk); idle_a("A idle1", 3);
        @(negedge clk); idle_a("A idle2", 3);
        en_a = 1'b1;
        slot_run_a(3, onehot_lo(3), 1'b0);

        // Asynchronous reset mid-slot at idx=2, cnt=4
        slot_run_a(0, onehot_lo(0), 1'b0);
        slot_run_a(1, onehot_lo(1), 1'b0);
        for (int c = 0; c < 5; c++) cyc_a(c, 2, onehot_lo(2), 1'b0);
        rst_a = 1'b1;
        #1 idle_a("A async rst", 0);
        @(negedge clk);
        idle_a("A rst hold", 0);
        rst_a = 1'b0;
        slot_run_a(0, onehot_lo(0), 1'b0);
        slot_run_a(1, onehot_lo(1), 1'b0);

        // Active-high, 3 digits: wrap 2 -> 0
        rst_b = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 8; c++) cyc_b(c, s % 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
